// File: rtl/multiplier_nbits_pipelined.sv
// multiplier_nbits_pipelined
//   Pipelined WIDTH x WIDTH multiplier producing a full 2*WIDTH-bit product.
//   Stage 1 forms the partial products. Rows are reduced by levels of 3:2
//   full/half-adder compressors, and the levels are spread across the PIPE
//   stages. The last stage finishes with a carry-propagate adder into the
//   product register. All stages advance together when the output is empty
//   or is being taken, so the pipeline runs at one result per cycle.
//
//   Optional feature macro: MULT_SIGNED_EN (adds in_signed, two's complement).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears valids, product, out_count
//   in_valid   operand pair present on A/B
//   in_ready   block accepts operands this cycle (equals advance)
//   A, B       multiplicand / multiplier, WIDTH bits each
//   in_signed  (MULT_SIGNED_EN only) treat A/B as two's complement
//   out_valid  product holds a result
//   out_ready  consumer takes the result this cycle
//   product    full-width product, 2*WIDTH bits
//   out_count  completed output transfers, wraps at 16 bits
module multiplier_nbits_pipelined #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PIPE  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef MULT_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [15:0]        out_count
);

    localparam int unsigned PW = 2 * WIDTH;
    // WIDTH partial-product rows plus one row of sign-correction constants
    localparam int unsigned NR = WIDTH + 1;

    typedef logic [NR-1:0][PW-1:0] rows_t;

    // Number of live rows after a given number of 3:2 levels
    function automatic int unsigned rows_after(input int unsigned levels);
        int unsigned n;
        n = NR;
        for (int unsigned i = 0; i < levels; i++) n = n - n / 3;
        return n;
    endfunction

    // Levels needed to bring NR rows down to two
    function automatic int unsigned count_levels();
        int unsigned n;
        int unsigned l;
        n = NR;
        l = 0;
        while (n > 2) begin
            n = n - n / 3;
            l = l + 1;
        end
        return l;
    endfunction

    localparam int unsigned LEVELS = count_levels();

    // One compressor level: each full group of three rows becomes a sum row
    // and a shifted carry row; leftover rows pass through. Live rows stay
    // packed at the low indices and everything above them is zero.
    function automatic rows_t csa_level(input rows_t r, input int unsigned n);
        rows_t         o;
        int unsigned   g3;
        int unsigned   rem;
        logic [PW-1:0] x, y, z;
        o   = '0;
        g3  = n / 3;
        rem = n - 3 * g3;
        for (int unsigned g = 0; g < NR / 3; g++) begin
            if (g < g3) begin
                x          = r[3*g];
                y          = r[3*g+1];
                z          = r[3*g+2];
                o[2*g]     = x ^ y ^ z;
                o[2*g+1]   = ((x & y) | (x & z) | (y & z)) << 1;
            end
        end
        for (int unsigned k = 0; k < 2; k++) begin
            if (k < rem) o[2*g3+k] = r[3*g3+k];
        end
        return o;
    endfunction

    // Partial products. In signed mode the Baugh-Wooley form is used: bits
    // pairing exactly one operand MSB are inverted and constants 2^WIDTH and
    // 2^(2*WIDTH-1) are added, giving the two's complement product modulo
    // 2^(2*WIDTH). Signedness is therefore folded into the rows here and
    // travels down the pipeline inside them.
    function automatic rows_t pp_gen(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic             s);
        rows_t r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                r[i][i+j] = (a[j] & b[i]) ^ (s & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        r[WIDTH][WIDTH] = s;
        r[WIDTH][PW-1]  = s;
        return r;
    endfunction

    logic            sgn;
    logic            advance;
    logic [PIPE-1:0] vld;
    rows_t           stg_in [PIPE];

`ifdef MULT_SIGNED_EN
    assign sgn = in_signed;
`else
    assign sgn = 1'b0;
`endif

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld[PIPE-1];
    assign stg_in[0] = pp_gen(A, B, sgn);

    // Valid bits shift with the data; an idle input inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (advance) begin
            vld <= (vld << 1) | PIPE'(in_valid);
        end
    end

    for (genvar p = 0; p < PIPE; p++) begin : g_stage
        localparam int unsigned L0 = (p * LEVELS) / PIPE;
        localparam int unsigned L1 = ((p + 1) * LEVELS) / PIPE;

        rows_t red;

        always_comb begin
            red = stg_in[p];
            for (int unsigned l = L0; l < L1; l++) begin
                red = csa_level(red, rows_after(l));
            end
        end

        if (p < PIPE - 1) begin : g_mid
            rows_t q;

            always_ff @(posedge clk) begin
                if (advance) q <= red;
            end

            assign stg_in[p+1] = q;
        end else begin : g_last
            logic [PW-1:0] cpa;

            // Only rows 0 and 1 are non-zero once the tree has finished
            always_comb begin
                cpa = '0;
                for (int unsigned k = 0; k < NR; k++) cpa = cpa + red[k];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    product <= '0;
                end else if (advance) begin
                    product <= cpa;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_multiplier_nbits_pipelined.sv
// Self-checking bench for multiplier_nbits_pipelined (WIDTH=8, PIPE=3).
// A queue-based model predicts products in acceptance order from plain
// arithmetic; directed scenarios add literal expectations.
module tb_multiplier_nbits_pipelined;

    localparam int unsigned W = 8;
    localparam int unsigned P = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
`ifdef MULT_SIGNED_EN
    logic           sgn_in;
`endif
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic [15:0]    out_count;

    int             errors = 0;
    int             checks = 0;
    logic [2*W-1:0] exp_q [$];
    logic [15:0]    m_count = '0;
    logic           stalled = 1'b0;
    logic [2*W-1:0] held = '0;

    always #5 clk = ~clk;

    multiplier_nbits_pipelined #(.WIDTH(W), .PIPE(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
`ifdef MULT_SIGNED_EN
        .in_signed (sgn_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_count (out_count)
    );

    function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] x,
                                                 input logic [W-1:0] y,
                                                 input logic         s);
        logic [2*W-1:0] xe;
        logic [2*W-1:0] ye;
        xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ye = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        a        = x;
        b        = y;
    endtask

    // Scoreboard: sampled mid-cycle, describing what the next edge will do
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (rst === 1'b1) begin
            exp_q.delete();
            m_count = '0;
            stalled = 1'b0;
        end else if (rst === 1'b0) begin
            chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            chk("out_count", {16'b0, out_count}, {16'b0, m_count});
            if (stalled) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_product", {16'b0, product}, {16'b0, held});
            end
            if (exp_q.size() == 0) begin
                chk("phantom_out", {31'b0, out_valid}, 32'd0);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("product", {16'b0, product}, {16'b0, e});
                m_count = m_count + 16'd1;
            end
            if (in_valid && in_ready) begin
`ifdef MULT_SIGNED_EN
                exp_q.push_back(model_mul(a, b, sgn_in));
`else
                exp_q.push_back(model_mul(a, b, 1'b0));
`endif
            end
            stalled = out_valid && !out_ready;
            held    = product;
        end
    end

    initial begin
        logic [2*W-1:0] seq_exp [4];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
`ifdef MULT_SIGNED_EN
        sgn_in    = 1'b0;
`endif
        tick();
        tick();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_product", {16'b0, product}, 32'd0);
        chk("reset_out_count", {16'b0, out_count}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();
        chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        // Back-to-back pairs, results on four consecutive cycles
        seq_exp[0] = 16'h000F;
        seq_exp[1] = 16'h0000;
        seq_exp[2] = 16'h0100;
        seq_exp[3] = 16'h00FF;
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: put(8'd3, 8'd5);
                1: put(8'd0, 8'd7);
                2: put(8'h80, 8'd2);
                3: put(8'hFF, 8'd1);
                default: in_valid = 1'b0;
            endcase
            tick();
            if (c >= 2 && c <= 5) begin
                chk("b2b_valid", {31'b0, out_valid}, 32'd1);
                chk("b2b_product", {16'b0, product}, {16'b0, seq_exp[c-2]});
            end
        end
        chk("b2b_count", {16'b0, out_count}, 32'd4);

        // Latency: result visible exactly PIPE edges after acceptance
        put(8'hFF, 8'hFF);
        tick();
        in_valid = 1'b0;
        chk("lat_edge1", {31'b0, out_valid}, 32'd0);
        tick();
        chk("lat_edge2", {31'b0, out_valid}, 32'd0);
        tick();
        chk("lat_edge3_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_edge3_product", {16'b0, product}, 32'h0000FE01);
        tick();

        // Full pipeline held by out_ready=0
        out_ready = 1'b0;
        put(8'd7, 8'd9);
        tick();
        put(8'h10, 8'h10);
        tick();
        put(8'hAB, 8'hCD);
        tick();
        put(8'h12, 8'h34);
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_product", {16'b0, product}, 32'h0000003F);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("release_p1", {16'b0, product}, 32'h00000100);
        tick();
        chk("release_p2", {16'b0, product}, 32'h000088EF);
        tick();
        chk("release_p3", {16'b0, product}, 32'h000003A8);
        tick();
        chk("release_empty", {31'b0, out_valid}, 32'd0);

`ifdef MULT_SIGNED_EN
        sgn_in = 1'b1;
        put(8'h80, 8'h80);
        tick();
        put(8'hFF, 8'h01);
        tick();
        sgn_in = 1'b0;
        put(8'hFF, 8'h01);
        tick();
        in_valid = 1'b0;
        chk("signed_min_sq", {16'b0, product}, 32'h00004000);
        tick();
        chk("signed_neg1", {16'b0, product}, 32'h0000FFFF);
        tick();
        chk("unsigned_ff", {16'b0, product}, 32'h000000FF);
        tick();
`endif

        // Mixed traffic with irregular valid/ready
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef MULT_SIGNED_EN
            sgn_in    = $urandom_range(0, 1) != 0;
`endif
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef MULT_SIGNED_EN
        sgn_in    = 1'b0;
`endif
        for (int k = 0; k < 6; k++) tick();
        chk("mixed_drained", exp_q.size(), 32'd0);

        // Reset with two pairs in flight and a handshake on the reset edge
        put(8'd5, 8'd6);
        tick();
        put(8'd9, 8'd9);
        tick();
        rst = 1'b1;
        put(8'd2, 8'd2);
        tick();
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_count", {16'b0, out_count}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("midrst_no_stale", {31'b0, out_valid}, 32'd0);
        end

        // 65536 transfers wrap the counter back to zero
        for (int i = 0; i < 65536; i++) begin
            put(W'(i), W'(i >> 8));
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("wrap_count", {16'b0, out_count}, 32'd0);
        chk("wrap_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
